cmd_phys_ctrl: RTL and testbench

Sequencer for the CMD-line physical layer of the SD host. Accepts a command frame from the CMD layer and drives the parallel-to-serial converter through load and send phases. Controls the CMD pad output enable, then releases the line and captures the card's response (none, 48-bit or 136-bit) with an Ncr timeout. Reports completion and error status back to the CMD layer.

---
 rtl/cmd_phys_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cmd_phys_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_phys_ctrl.sv
// CMD-line physical sequencer: loads and shifts a command frame out through the
// serializer, then turns the line around and captures an optional card response.
module cmd_phys_ctrl #(
  parameter int FRAME_BITS   = 48,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  cmd_req,
  input  logic [FRAME_BITS-1:0] cmd_frame,
  input  logic [1:0]            resp_type,
  output logic                  cmd_ack,
  output logic [FRAME_BITS-1:0] ser_parallel,
  output logic                  ser_enable,
  output logic                  ser_load_send,
  input  logic                  ser_complete,
  output logic                  cmd_oe,
  input  logic                  cmd_in,
  output logic [135:0]          resp_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            status
);

  localparam int MAX_BITS = (FRAME_BITS > 136) ? FRAME_BITS : 136;
  localparam int BIT_W    = $clog2(MAX_BITS);
  localparam int WAIT_W   = $clog2(RESP_TIMEOUT + 1);
  localparam logic [BIT_W-1:0]  FRAME_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]  SHORT_LAST = BIT_W'(46);
  localparam logic [BIT_W-1:0]  LONG_LAST  = BIT_W'(134);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_TURN, S_NCR, S_RECV, S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [WAIT_W-1:0]     wait_cnt_reg;
  logic                  sticky_reg;
  logic [1:0]            rtype_reg;
  logic [FRAME_BITS-1:0] ser_parallel_reg;
  logic [135:0]          resp_data_reg;
  logic [2:0]            status_reg;
  logic cmd_ack_reg, ser_enable_reg, ser_load_send_reg, cmd_oe_reg, busy_reg, done_reg;
  logic cmd_ack_next, ser_enable_next, ser_load_send_next, cmd_oe_next, busy_next, done_next;
  logic                  resp_en;
  logic [BIT_W-1:0]      recv_last;

  // Response length is fixed by the type latched at request time; 11 behaves as none.
  assign resp_en   = (rtype_reg == 2'b01) || (rtype_reg == 2'b10);
  assign recv_last = (rtype_reg == 2'b10) ? LONG_LAST : SHORT_LAST;

  // Outputs are registered from the next state so each is high exactly in its state.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      cmd_ack_reg       <= 1'b0;
      ser_enable_reg    <= 1'b0;
      ser_load_send_reg <= 1'b0;
      cmd_oe_reg        <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cmd_ack_reg       <= cmd_ack_next;
      ser_enable_reg    <= ser_enable_next;
      ser_load_send_reg <= ser_load_send_next;
      cmd_oe_reg        <= cmd_oe_next;
      busy_reg          <= busy_next;
      done_reg          <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (cmd_req) state_next = S_LOAD;
      S_LOAD: state_next = S_SEND;
      S_SEND: if (bit_cnt_reg == FRAME_LAST) state_next = S_TURN;
      S_TURN: state_next = resp_en ? S_NCR : S_DONE;
      S_NCR: begin
        if (!cmd_in)                        state_next = S_RECV;
        else if (wait_cnt_reg == WAIT_LAST) state_next = S_DONE;
      end
      S_RECV: if (bit_cnt_reg == recv_last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ack_next       = (state_next == S_LOAD);
    ser_enable_next    = (state_next == S_LOAD);
    ser_load_send_next = (state_next == S_SEND);
    cmd_oe_next        = (state_next == S_SEND) || (state_next == S_TURN);
    busy_next          = (state_next != S_IDLE);
    done_next          = (state_next == S_DONE);
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      bit_cnt_reg      <= '0;
      wait_cnt_reg     <= '0;
      sticky_reg       <= 1'b0;
      rtype_reg        <= 2'b00;
      ser_parallel_reg <= '0;
      resp_data_reg    <= '0;
      status_reg       <= 3'b000;
    end else begin
      case (state_reg)
        S_IDLE: begin
          bit_cnt_reg  <= '0;
          wait_cnt_reg <= '0;
          sticky_reg   <= 1'b0;
          if (cmd_req) begin
            ser_parallel_reg <= cmd_frame;
            rtype_reg        <= resp_type;
            resp_data_reg    <= '0;
            status_reg       <= 3'b000;
          end
        end
        S_SEND: begin
          bit_cnt_reg <= (bit_cnt_reg == FRAME_LAST) ? '0 : bit_cnt_reg + 1'b1;
          if (ser_complete) sticky_reg <= 1'b1;
        end
        S_TURN: begin
          status_reg[2] <= ~sticky_reg;
          bit_cnt_reg   <= '0;
          wait_cnt_reg  <= '0;
        end
        S_NCR: begin
          if (!cmd_in)
            resp_data_reg <= {resp_data_reg[134:0], cmd_in};
          else if (wait_cnt_reg == WAIT_LAST)
            status_reg[1] <= 1'b1;
          else
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
        S_RECV: begin
          resp_data_reg <= {resp_data_reg[134:0], cmd_in};
          bit_cnt_reg   <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == recv_last) status_reg[0] <= ~cmd_in;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ack       = cmd_ack_reg;
  assign ser_enable    = ser_enable_reg;
  assign ser_load_send = ser_load_send_reg;
  assign cmd_oe        = cmd_oe_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign ser_parallel  = ser_parallel_reg;
  assign resp_data     = resp_data_reg;
  assign status        = status_reg;

endmodule

// File: tb/tb_cmd_phys_ctrl.sv
// Scoreboard bench for cmd_phys_ctrl: stimulus pushes expected transaction
// outcomes, a negedge monitor pops and compares them when done pulses.
module tb_cmd_phys_ctrl;
  localparam int FB = 48;
  localparam int RT = 64;

  logic          sd_clock = 1'b0;
  logic          reset;
  logic          cmd_req;
  logic [FB-1:0] cmd_frame;
  logic [1:0]    resp_type;
  logic          cmd_ack;
  logic [FB-1:0] ser_parallel;
  logic          ser_enable;
  logic          ser_load_send;
  logic          ser_complete;
  logic          cmd_oe;
  logic          cmd_in;
  logic [135:0]  resp_data;
  logic          busy;
  logic          done;
  logic [2:0]    status;
  bit            ser_ok = 1'b1;

  cmd_phys_ctrl #(.FRAME_BITS(FB), .RESP_TIMEOUT(RT)) dut (
    .sd_clock(sd_clock), .reset(reset), .cmd_req(cmd_req), .cmd_frame(cmd_frame),
    .resp_type(resp_type), .cmd_ack(cmd_ack), .ser_parallel(ser_parallel),
    .ser_enable(ser_enable), .ser_load_send(ser_load_send), .ser_complete(ser_complete),
    .cmd_oe(cmd_oe), .cmd_in(cmd_in), .resp_data(resp_data), .busy(busy),
    .done(done), .status(status)
  );

  always #5 sd_clock = ~sd_clock;

  // Serializer model: reports completion while shifting unless a fault is injected.
  assign ser_complete = ser_ok & ser_load_send;

  int cyc = 0;
  always @(posedge sd_clock) cyc <= cyc + 1;

  typedef struct {
    int           ack_cyc;
    int           done_cyc;
    logic [FB-1:0] frame;
    logic [135:0] resp;
    logic [2:0]   status;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   ack_cnt  = 0;
  int   ls_cnt   = 0;
  int   oe_cnt   = 0;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int resp_len(input logic [1:0] rt);
    return (rt == 2'b01) ? 48 : (rt == 2'b10) ? 136 : 0;
  endfunction

  // Reference: transaction outcome from frame length, Ncr delay k and response bits.
  function automatic exp_t model(input logic [FB-1:0] frame, input logic [1:0] rt, input int k,
                                 input logic [135:0] pat, input bit ok, input int c0);
    exp_t e;
    int len;
    logic [135:0] m;
    len = resp_len(rt);
    e.frame   = frame;
    e.ack_cyc = c0 + 1;
    e.resp    = '0;
    e.status  = {~ok, 2'b00};
    if (len == 0) begin
      e.done_cyc = c0 + FB + 3;
    end else if (k >= RT) begin
      e.done_cyc  = c0 + FB + 3 + RT;
      e.status[1] = 1'b1;
    end else begin
      m = '1;
      m = m >> (136 - len);
      e.done_cyc  = c0 + FB + 3 + k + len;
      e.resp      = pat & m;
      e.status[0] = ~pat[0];
    end
    return e;
  endfunction

  function automatic logic [135:0] rnd136();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[135:0];
  endfunction

  always @(negedge sd_clock) begin
    if (reset) begin
      ack_cnt = 0;
      ls_cnt  = 0;
      oe_cnt  = 0;
    end else begin
      if (cmd_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ack: got cmd_ack=1 at cycle %0d expected no transaction", cyc);
        end else begin
          chk("ack_cycle", 136'(cyc), 136'(exp_q[0].ack_cyc));
          chk("ser_parallel", 136'(ser_parallel), 136'(exp_q[0].frame));
          chk("ser_enable_with_ack", 136'(ser_enable), 136'(1));
        end
      end
      ls_cnt += int'(ser_load_send);
      oe_cnt += int'(cmd_oe);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          $display("txn done: cycle=%0d status=%03b resp=%0h", cyc, status, resp_data);
          chk("done_cycle", 136'(cyc), 136'(mon_e.done_cyc));
          chk("status", 136'(status), 136'(mon_e.status));
          chk("resp_data", resp_data, mon_e.resp);
          chk("ack_count", 136'(ack_cnt), 136'(1));
          chk("load_send_cycles", 136'(ls_cnt), 136'(FB));
          chk("cmd_oe_cycles", 136'(oe_cnt), 136'(FB + 1));
          chk("busy_at_done", 136'(busy), 136'(1));
        end
        ack_cnt = 0;
        ls_cnt  = 0;
        oe_cnt  = 0;
      end
    end
  end

  // Must be called just after a rising edge with the DUT idle.
  task automatic do_txn(input logic [FB-1:0] frame, input logic [1:0] rt, input int k,
                        input logic [135:0] pat, input bit ok, input int hold);
    int c0, len, start, d0;
    logic [135:0] p;
    bit finished;
    len = resp_len(rt);
    p = pat;
    if (len > 0) p[len-1] = 1'b0;
    start = FB + 3 + k;
    ser_ok = ok;
    c0 = cyc;
    d0 = done_cnt;
    exp_q.push_back(model(frame, rt, k, p, ok, c0));
    cmd_frame = frame;
    resp_type = rt;
    cmd_req   = 1'b1;
    cmd_in    = 1'b1;
    finished  = 1'b0;
    for (int rr = 1; rr < 400; rr++) begin
      @(posedge sd_clock); #1;
      if (done_cnt != d0) begin
        finished = 1'b1;
        cmd_in   = 1'b1;
        break;
      end
      cmd_req = (rr <= 1 + hold);
      if (!cmd_req) begin
        cmd_frame = FB'({$urandom(), $urandom()});
        resp_type = 2'($urandom());
      end
      if (rr >= 2 && rr <= FB + 2)
        cmd_in = 1'($urandom());
      else if (len > 0 && k < RT && rr >= start && rr < start + len)
        cmd_in = p[len - 1 - (rr - start)];
      else
        cmd_in = 1'b1;
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout: got no done within 400 cycles expected done at cycle %0d",
               c0 + FB + 3);
      reset = 1'b1;
      @(posedge sd_clock); #1;
      reset = 1'b0;
      exp_q.delete();
      @(posedge sd_clock); #1;
    end
  endtask

  initial begin
    int c0, d0, rt, k, hold;
    logic [135:0] pat;
    reset = 1'b1; cmd_req = 1'b0; cmd_in = 1'b1; cmd_frame = '0; resp_type = 2'b00;
    repeat (3) @(posedge sd_clock);
    @(negedge sd_clock);
    chk("reset_ctrl", 136'({cmd_oe, ser_enable, ser_load_send, cmd_ack, done, busy, status}), 136'(0));
    chk("reset_resp", resp_data, 136'(0));
    chk("reset_par", 136'(ser_parallel), 136'(0));
    #1 reset = 1'b0;
    @(posedge sd_clock); #1;

    // Abort in mid-SEND: outputs clear asynchronously and no done is issued.
    c0 = cyc;
    d0 = done_cnt;
    exp_q.push_back(model(48'h40_0000_0000_95, 2'b00, 0, '0, 1'b1, c0));
    cmd_frame = 48'h40_0000_0000_95; resp_type = 2'b00; cmd_req = 1'b1;
    for (int rr = 1; rr <= 20; rr++) begin
      @(posedge sd_clock); #1;
      cmd_req = (rr <= 1);
    end
    #2;
    chk("mid_send_load_send", 136'(ser_load_send), 136'(1));
    reset = 1'b1;
    #1;
    chk("abort_ctrl", 136'({cmd_oe, ser_enable, ser_load_send, cmd_ack, done, busy, status}), 136'(0));
    chk("abort_resp", resp_data, 136'(0));
    chk("abort_par", 136'(ser_parallel), 136'(0));
    $display("txn aborted by reset at relative cycle 20");
    @(negedge sd_clock); #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (80) @(posedge sd_clock);
    chk("no_done_after_abort", 136'(done_cnt), 136'(d0));
    #1;

    do_txn(48'h40_0000_0000_95, 2'b00, 0, '0, 1'b1, 0);
    do_txn(48'h48_0000_01AA_87, 2'b01, 5, 136'(48'h08_0000_01AA_87), 1'b1, 0);
    pat = rnd136(); pat[0] = 1'b0;
    do_txn(48'h42_0000_0000_4D, 2'b10, 3, pat, 1'b1, 0);
    do_txn(48'h77_0000_0000_11, 2'b01, RT, '0, 1'b1, 0);
    do_txn(48'h42_1234_5678_9B, 2'b10, 7, rnd136(), 1'b0, 3);
    do_txn(48'h40_0000_0000_95, 2'b11, 0, '0, 1'b1, 0);
    do_txn(48'h48_0000_01AA_87, 2'b01, 0, rnd136(), 1'b1, 0);
    do_txn(48'h48_0000_01AA_87, 2'b01, RT - 1, rnd136(), 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      rt   = int'($urandom_range(0, 3));
      k    = int'($urandom_range(0, RT + 5));
      hold = int'($urandom_range(0, 3));
      do_txn(FB'({$urandom(), $urandom()}), 2'(rt), k, rnd136(), ($urandom_range(0, 3) != 0), hold);
    end

    repeat (3) @(posedge sd_clock);
    chk("queue_drained", 136'(exp_q.size()), 136'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
